sram_stream_reader: RTL and testbench

//  Read-side sequencer for the 128b x 2048 activation/weight SRAM (sync read, 1-cycle latency).

---
 rtl/sram_stream_reader_pkg.sv | 20 ++
 rtl/sram_stream_reader_if.sv | 29 ++
 rtl/sram_rd_skid.sv | 42 ++++
 rtl/sram_stream_reader.sv | 100 ++++++++++
 tb/tb_sram_stream_reader.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sram_stream_reader_pkg.sv
// Shared widths, FSM encoding and address helper for the SRAM stream reader.
package sram_stream_reader_pkg;

  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 11;
  localparam int unsigned LEN_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Row address of the n-th beat; wraps modulo the SRAM depth.
  function automatic logic [AW-1:0] row_addr(input logic [AW-1:0] base,
                                             input logic [LEN_W-1:0] offset);
    return base + AW'(offset);
  endfunction

endpackage

// File: rtl/sram_stream_reader_if.sv
// Control, SRAM and stream signals of the SRAM stream reader.
interface sram_stream_reader_if;

  logic                                      start;
  logic [sram_stream_reader_pkg::AW-1:0]     base_addr;
  logic [sram_stream_reader_pkg::LEN_W-1:0]  length;
  logic                                      busy;
  logic                                      done;
  logic                                      sram_cen;
  logic                                      sram_wen;
  logic [sram_stream_reader_pkg::AW-1:0]     sram_a;
  logic [sram_stream_reader_pkg::DW-1:0]     sram_q;
  logic [sram_stream_reader_pkg::DW-1:0]     out_data;
  logic                                      out_valid;
  logic                                      out_ready;

  // Reader side.
  modport slave (
    input  start, base_addr, length, sram_q, out_ready,
    output busy, done, sram_cen, sram_wen, sram_a, out_data, out_valid
  );

  // Requester / SRAM / downstream side.
  modport master (
    output start, base_addr, length, sram_q, out_ready,
    input  busy, done, sram_cen, sram_wen, sram_a, out_data, out_valid
  );

endinterface

// File: rtl/sram_rd_skid.sv
// Two-entry FIFO absorbing the SRAM read latency and downstream backpressure.
module sram_rd_skid
  import sram_stream_reader_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    occ
);

  logic [DW-1:0] entry_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;

  // Storage and pointers; the issue logic keeps push from ever overfilling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      if (push) begin
        entry_q[wr_ptr_q] <= din;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign dout = entry_q[rd_ptr_q];
  assign occ  = cnt_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Issues back-to-back SRAM row reads and streams the rows out over valid/ready.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  sram_stream_reader_if.slave  bus
);

  state_t           state_q;
  state_t           state_nxt;
  logic [AW-1:0]    base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued_q;
  logic             inflight_q;
  logic [AW-1:0]    addr_q;

  logic             issue;
  logic             pop;
  logic             skid_valid;
  logic [1:0]       occ;
  logic [2:0]       pending;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    head;
  logic             accept;
  logic             last_retire;

  assign accept     = (state_q == ST_IDLE) && bus.start;
  assign skid_valid = (occ != 2'd0);
  assign pop        = skid_valid && bus.out_ready;

  // Rows already owed to the skid after this cycle's pop; at most two may be outstanding.
  assign pending = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign issue   = (state_q == ST_RUN) && (issued_q < len_q) && (pending < 3'd2);
  assign rd_addr = row_addr(base_q, issued_q);

  // RUN ends on the edge that retires the final beat, so DONE is the following cycle.
  assign last_retire = (issued_q == len_q) && !inflight_q && (occ == 2'(pop));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_nxt;
      inflight_q <= issue;
      if (accept) begin
        base_q   <= bus.base_addr;
        len_q    <= bus.length;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + LEN_W'(1);
      end
      if (issue) begin
        addr_q <= rd_addr;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.length != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (last_retire) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  sram_rd_skid u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .din   (bus.sram_q),
    .pop   (pop),
    .dout  (head),
    .occ   (occ)
  );

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.sram_cen  = ~issue;
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_a    = issue ? rd_addr : addr_q;
  assign bus.out_valid = skid_valid;
  assign bus.out_data  = head;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader with a behavioural 128b x 2048 sync-read SRAM.
module tb_sram_stream_reader;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sram_stream_reader_if bus ();

  sram_stream_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded row i holds i in every 32-bit lane.
  function automatic logic [127:0] row_data(input int a);
    logic [31:0] lane;
    lane = 32'(a & 2047);
    return {lane, lane, lane, lane};
  endfunction

  always @(posedge clk) begin
    if (!bus.sram_cen) bus.sram_q <= row_data(int'(bus.sram_a));
  end

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (c >= 3 && c <= 7) return 1'b0;
    if (c < 3) return 1'b1;
    return ((c % 2) == 1);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 128'(bus.busy), 128'(0));
    check({tag, "_done"}, 128'(bus.done), 128'(0));
    check({tag, "_cen"}, 128'(bus.sram_cen), 128'(1));
    check({tag, "_a"}, 128'(bus.sram_a), 128'(0));
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_data"}, bus.out_data, 128'(0));
  endtask

  task automatic run_job(input int b, input int len, input int mode, input int restart_c,
                         input string tag);
    int n_iss, beats, outst, addr_bad, data_bad, stable_bad, ovf, done_cnt;
    int done_c, first_valid, first_pop, last_pop, first_addrs[4];
    logic busy_c1, after_busy, after_done, finished, prev_stall, pop, iss;
    logic [127:0] prev_data;
    n_iss = 0; beats = 0; outst = 0; addr_bad = 0; data_bad = 0; stable_bad = 0;
    ovf = 0; done_cnt = 0; done_c = -1; first_valid = -1; first_pop = -1; last_pop = -1;
    busy_c1 = 1'b0; after_busy = 1'b1; after_done = 1'b1; finished = 1'b0;
    prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < 4; i++) first_addrs[i] = -1;

    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 11'(b); bus.length = 12'(len); bus.out_ready = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      bus.start = (c == restart_c);
      if (c == restart_c) begin
        bus.base_addr = 11'd500; bus.length = 12'd3;
      end
      bus.out_ready = ready_for(mode, c);
      #1;
      iss = !bus.sram_cen;
      pop = bus.out_valid && bus.out_ready;
      if (iss) begin
        if (n_iss < 4) first_addrs[n_iss] = int'(bus.sram_a);
        if (int'(bus.sram_a) != ((b + n_iss) & 2047)) addr_bad++;
        n_iss++;
      end
      if (outst - int'(pop) + int'(iss) > 2) ovf++;
      outst = outst - int'(pop) + int'(iss);
      if (prev_stall && bus.out_valid && bus.out_data !== prev_data) stable_bad++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.out_valid && first_valid < 0) first_valid = c;
      if (pop) begin
        if (bus.out_data !== row_data(b + beats)) data_bad++;
        if (beats == 0) first_pop = c;
        last_pop = c;
        beats++;
      end
      if (c == 1) busy_c1 = bus.busy;
      if (bus.done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) begin
        after_busy = bus.busy;
        after_done = bus.done;
        finished   = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;

    check({tag, "_finished"}, 128'(finished), 128'(1));
    check({tag, "_busy_c1"}, 128'(busy_c1), 128'(1));
    check({tag, "_beats"}, 128'(beats), 128'(len));
    check({tag, "_issues"}, 128'(n_iss), 128'(len));
    check({tag, "_addr_bad"}, 128'(addr_bad), 128'(0));
    check({tag, "_data_bad"}, 128'(data_bad), 128'(0));
    check({tag, "_stable_bad"}, 128'(stable_bad), 128'(0));
    check({tag, "_overflow"}, 128'(ovf), 128'(0));
    check({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
    check({tag, "_done_cycle"}, 128'(done_c), 128'((len == 0) ? 1 : last_pop + 1));
    check({tag, "_busy_after"}, 128'(after_busy), 128'(0));
    check({tag, "_done_after"}, 128'(after_done), 128'(0));
    check({tag, "_wen"}, 128'(bus.sram_wen), 128'(1));
    if (len == 0) begin
      check({tag, "_no_valid"}, 128'(first_valid), 128'(-1));
    end else if (mode == 0) begin
      check({tag, "_first_valid"}, 128'(first_valid), 128'(3));
      check({tag, "_back_to_back"}, 128'(last_pop - first_pop), 128'(len - 1));
    end
    if (b == 2046) begin
      check({tag, "_a0"}, 128'(first_addrs[0]), 128'(2046));
      check({tag, "_a1"}, 128'(first_addrs[1]), 128'(2047));
      check({tag, "_a2"}, 128'(first_addrs[2]), 128'(0));
      check({tag, "_a3"}, 128'(first_addrs[3]), 128'(1));
    end
  endtask

  initial begin
    int got;
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0;

    run_job(0, 4, 0, -1, "t1");
    run_job(10, 8, 1, -1, "t2");
    run_job(2046, 4, 0, -1, "t3");
    run_job(0, 0, 0, -1, "t4");

    // Abandon a 16-row job after three beats with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 11'd0; bus.length = 12'd16; bus.out_ready = 1'b1;
    got = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check("t5_beat", bus.out_data, row_data(got));
        got++;
      end
      if (got == 3) break;
    end
    check("t5_three_beats", 128'(got), 128'(3));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle("t5_async");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("t5_post");
    run_job(100, 2, 0, -1, "t5_new");

    run_job(20, 6, 0, 2, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
